// File: rtl/cmult_pkg.sv
// rtl/cmult_pkg.sv - shared constants and result record for the complex-multiplier scheduler
package cmult_pkg;

  localparam int CM_N     = 8;
  localparam int CM_LAT   = 4;
  localparam int CM_NREQ  = 4;
  localparam int CM_DEPTH = 8;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  localparam int CM_IDW = id_width(CM_NREQ);

  typedef struct packed {
    logic [CM_IDW-1:0]        id;
    logic signed [2*CM_N-1:0] c_r;
    logic signed [2*CM_N-1:0] c_i;
  } res_t;

endpackage

// File: rtl/cmult_sched_if.sv
// rtl/cmult_sched_if.sv - requester and result-consumer signals of the multiplier scheduler
interface cmult_sched_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  localparam int IDW = cmult_pkg::id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*N-1:0]     req_a_r;
  logic [NREQ*N-1:0]     req_a_i;
  logic [NREQ*N-1:0]     req_b_r;
  logic [NREQ*N-1:0]     req_b_i;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDW-1:0]        res_id;
  logic signed [2*N-1:0] res_c_r;
  logic signed [2*N-1:0] res_c_i;

  modport master (
    output req_valid, req_a_r, req_a_i, req_b_r, req_b_i, res_ready,
    input  req_ready, res_valid, res_id, res_c_r, res_c_i
  );

  modport slave (
    input  req_valid, req_a_r, req_a_i, req_b_r, req_b_i, res_ready,
    output req_ready, res_valid, res_id, res_c_r, res_c_i
  );
endinterface

// File: rtl/cmult_res_fifo.sv
// rtl/cmult_res_fifo.sv - synchronous result FIFO; pointers carry one wrap bit for full/empty
module cmult_res_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Head data is forced to zero while empty so the outputs read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/compmult.sv
// rtl/compmult.sv - four-stage pipelined signed complex multiplier, results wrap modulo 2^(2N)
module compmult #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [N-1:0]   a_r,
  input  logic signed [N-1:0]   a_i,
  input  logic signed [N-1:0]   b_r,
  input  logic signed [N-1:0]   b_i,
  output logic signed [2*N-1:0] c_r,
  output logic signed [2*N-1:0] c_i
);

  logic signed [N-1:0]   ar0, ai0, br0, bi0;
  logic signed [2*N-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*N-1:0] s_r, s_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar0  <= '0;
      ai0  <= '0;
      br0  <= '0;
      bi0  <= '0;
      p_rr <= '0;
      p_ii <= '0;
      p_ri <= '0;
      p_ir <= '0;
      s_r  <= '0;
      s_i  <= '0;
      c_r  <= '0;
      c_i  <= '0;
    end else begin
      ar0  <= a_r;
      ai0  <= a_i;
      br0  <= b_r;
      bi0  <= b_i;
      p_rr <= ar0 * br0;
      p_ii <= ai0 * bi0;
      p_ri <= ar0 * bi0;
      p_ir <= ai0 * br0;
      // The imaginary sum can reach 2^(2N-1) and wraps; that is intended.
      s_r  <= p_rr - p_ii;
      s_i  <= p_ri + p_ir;
      c_r  <= s_r;
      c_i  <= s_i;
    end
  end

endmodule

// File: rtl/cmult_sched.sv
// rtl/cmult_sched.sv - round-robin sharing of one pipelined complex multiplier among NREQ lanes,
// with a tag pipe alongside the multiplier and a credit-protected result FIFO
module cmult_sched
  import cmult_pkg::*;
#(
  parameter int N     = CM_N,
  parameter int NREQ  = CM_NREQ,
  parameter int DEPTH = CM_DEPTH
) (
  input logic         clk,
  input logic         reset,
  cmult_sched_if.slave bus
);

  localparam int LAT = CM_LAT;
  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int W   = IDW + 4 * N;

  logic [IDW-1:0]        rr_ptr;
  logic [IDW-1:0]        gnt;
  logic [CW-1:0]         cred;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LAT-1:0]        tag_v;
  logic [IDW-1:0]        tag_id [LAT];
  logic signed [N-1:0]   m_ar, m_ai, m_br, m_bi;
  logic signed [2*N-1:0] m_cr, m_ci;
  logic [W-1:0]          head;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[IDW'(idx)]) begin
        gnt   = IDW'(idx);
        found = 1'b1;
      end
    end
  end

  assign accept        = !reset && (cred != '0) && (|bus.req_valid);
  assign bus.req_ready = accept ? (NREQ'(1) << gnt) : '0;
  assign pop           = bus.res_valid && bus.res_ready;
  assign push          = tag_v[LAT-1];

  always_comb begin
    m_ar = '0;
    m_ai = '0;
    m_br = '0;
    m_bi = '0;
    if (accept) begin
      m_ar = bus.req_a_r[int'(gnt)*N +: N];
      m_ai = bus.req_a_i[int'(gnt)*N +: N];
      m_br = bus.req_b_r[int'(gnt)*N +: N];
      m_bi = bus.req_b_i[int'(gnt)*N +: N];
    end
  end

  compmult #(.N(N)) u_mult (
    .clk   (clk),
    .reset (reset),
    .a_r   (m_ar),
    .a_i   (m_ai),
    .b_r   (m_br),
    .b_i   (m_bi),
    .c_r   (m_cr),
    .c_i   (m_ci)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      cred   <= CW'(DEPTH);
      tag_v  <= '0;
      for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
    end else begin
      if (accept) rr_ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      // Tag pipe never stalls, matching the multiplier it shadows.
      tag_v     <= {tag_v[LAT-2:0], accept};
      tag_id[0] <= accept ? gnt : '0;
      for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
      if (accept && !pop)      cred <= cred - 1'b1;
      else if (!accept && pop) cred <= cred + 1'b1;
    end
  end

  cmult_res_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({tag_id[LAT-1], m_cr, m_ci}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.res_valid = !fifo_empty;
  assign bus.res_id    = head[W-1 -: IDW];
  assign bus.res_c_r   = head[4*N-1 -: 2*N];
  assign bus.res_c_i   = head[2*N-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));
  a_cred_range:  assert property (@(posedge clk) disable iff (reset) cred <= CW'(DEPTH));

endmodule

// File: tb/tb_cmult_sched.sv
// tb/tb_cmult_sched.sv - directed table, corner sequences and random scoreboard for cmult_sched
module tb_cmult_sched;
  import cmult_pkg::*;

  localparam int N     = 8;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;

  typedef struct {
    logic signed [N-1:0]   ar, ai, br, bi;
    logic signed [2*N-1:0] cr, ci;
  } vec_t;

  typedef struct {
    res_t r;
    int   due;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  logic signed [N-1:0] op_ar [NREQ];
  logic signed [N-1:0] op_ai [NREQ];
  logic signed [N-1:0] op_br [NREQ];
  logic signed [N-1:0] op_bi [NREQ];

  exp_t expq [$];
  int   m_rr;
  int   m_out;

  logic [NREQ-1:0]       last_ready;
  logic                  last_rv;
  logic [CM_IDW-1:0]     last_id;
  logic signed [2*N-1:0] last_cr, last_ci;

  vec_t tbl [7];

  cmult_sched_if #(.N(N), .NREQ(NREQ)) bus ();

  cmult_sched #(.N(N), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic res_t ref_mult(input int id, input logic signed [N-1:0] ar, input logic signed [N-1:0] ai,
                                    input logic signed [N-1:0] br, input logic signed [N-1:0] bi);
    res_t r;
    int   cr, ci;
    cr    = int'(ar) * int'(br) - int'(ai) * int'(bi);
    ci    = int'(ar) * int'(bi) + int'(ai) * int'(br);
    r.id  = CM_IDW'(id);
    r.c_r = 16'(cr);
    r.c_i = 16'(ci);
    return r;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check against the model, advance the model.
  task automatic run_cycle(input logic [NREQ-1:0] v, input logic rdy, input bit rnd);
    logic [NREQ-1:0] exp_ready;
    bit              exp_rv;
    int              eg;
    exp_t            e;
    if (rnd) begin
      for (int i = 0; i < NREQ; i++) begin
        op_ar[i] = N'($urandom);
        op_ai[i] = N'($urandom);
        op_br[i] = N'($urandom);
        op_bi[i] = N'($urandom);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a_r[i*N +: N] = op_ar[i];
      bus.req_a_i[i*N +: N] = op_ai[i];
      bus.req_b_r[i*N +: N] = op_br[i];
      bus.req_b_i[i*N +: N] = op_bi[i];
    end
    bus.req_valid = v;
    bus.res_ready = rdy;
    #1;
    exp_ready = '0;
    eg        = -1;
    if (m_out < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        if (eg < 0 && v[2'((m_rr + k) % NREQ)]) eg = (m_rr + k) % NREQ;
      end
      if (eg >= 0) exp_ready = NREQ'(1) << eg;
    end
    exp_rv     = (expq.size() != 0) && (expq[0].due <= cyc);
    last_ready = bus.req_ready;
    last_rv    = bus.res_valid;
    last_id    = bus.res_id;
    last_cr    = bus.res_c_r;
    last_ci    = bus.res_c_i;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    chk("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    chk("cred", 32'(dut.cred), DEPTH - m_out);
    if (exp_rv) begin
      chk("res_id", 32'(bus.res_id), 32'(expq[0].r.id));
      chk("res_c_r", 32'(bus.res_c_r), 32'(expq[0].r.c_r));
      chk("res_c_i", 32'(bus.res_c_i), 32'(expq[0].r.c_i));
      if (rdy) begin
        void'(expq.pop_front());
        m_out--;
      end
    end
    if (eg >= 0) begin
      e.r   = ref_mult(eg, op_ar[eg], op_ai[eg], op_br[eg], op_bi[eg]);
      e.due = cyc + 5;
      expq.push_back(e);
      m_rr = (eg + 1) % NREQ;
      m_out++;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int lat;
    int r;
    int thr;

    tests = 0;
    fails = 0;
    cyc   = 0;
    m_rr  = 0;
    m_out = 0;
    clk   = 1'b0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.req_a_r = '0;
    bus.req_a_i = '0;
    bus.req_b_r = '0;
    bus.req_b_i = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_ar[i] = '0;
      op_ai[i] = '0;
      op_br[i] = '0;
      op_bi[i] = '0;
    end

    tbl[0] = '{ar:  3,   ai:  4,   br:  5,   bi: -2,   cr: 23,    ci: 14};
    tbl[1] = '{ar: -128, ai: -128, br: -128, bi: -128, cr: 0,     ci: -32768};
    tbl[2] = '{ar: 127,  ai: 127,  br: 127,  bi: -128, cr: 32385, ci: -127};
    tbl[3] = '{ar: 0,    ai: 0,    br: 5,    bi: 5,    cr: 0,     ci: 0};
    tbl[4] = '{ar: 1,    ai: 0,    br: -1,   bi: 0,    cr: -1,    ci: 0};
    tbl[5] = '{ar: -1,   ai: -1,   br: -1,   bi: 1,    cr: 2,     ci: 0};
    tbl[6] = '{ar: 10,   ai: -20,  br: -30,  bi: 40,   cr: 500,   ci: 1000};

    // Reset state, with all requesters asserting valid.
    repeat (2) @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    chk("rst_res_c_r", 32'(bus.res_c_r), 0);
    chk("rst_res_c_i", 32'(bus.res_c_i), 0);
    chk("rst_cred", 32'(dut.cred), DEPTH);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // Table: one op at a time from a rotating requester, latency and value checks.
    for (int t = 0; t < 7; t++) begin
      r = t % NREQ;
      op_ar[r] = tbl[t].ar;
      op_ai[r] = tbl[t].ai;
      op_br[r] = tbl[t].br;
      op_bi[r] = tbl[t].bi;
      run_cycle(NREQ'(1) << r, 1'b1, 1'b0);
      chk("tbl_grant", 32'(last_ready), 32'(NREQ'(1) << r));
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        run_cycle('0, 1'b1, 1'b0);
        if (last_rv) begin
          lat = k;
          break;
        end
      end
      chk("tbl_latency", lat, 5);
      chk("tbl_id", 32'(last_id), r);
      chk("tbl_c_r", 32'(last_cr), 32'(tbl[t].cr));
      chk("tbl_c_i", 32'(last_ci), 32'(tbl[t].ci));
    end

    // Backpressure: exactly DEPTH accepts, then one pop frees exactly one slot.
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      run_cycle('1, 1'b0, 1'b1);
      if (last_ready != '0) acc++;
    end
    chk("bp_accepts", acc, DEPTH);
    chk("bp_stalled", 32'(last_ready), 0);
    run_cycle('1, 1'b1, 1'b1);
    chk("bp_pop_valid", 32'(last_rv), 1);
    chk("bp_pop_no_grant", 32'(last_ready), 0);
    run_cycle('1, 1'b0, 1'b1);
    chk("bp_regrant", 32'(last_ready != '0), 1);
    run_cycle('1, 1'b0, 1'b1);
    chk("bp_stalled_again", 32'(last_ready), 0);
    for (int k = 0; k < 20; k++) run_cycle('0, 1'b1, 1'b1);

    // Reset with three ops in flight and two queued.
    for (int k = 0; k < 5; k++) run_cycle('1, 1'b0, 1'b1);
    run_cycle('0, 1'b0, 1'b1);
    chk("pre_rst_outstanding", m_out, 5);
    bus.req_valid = '1;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    chk("midrst_res_valid", 32'(bus.res_valid), 0);
    chk("midrst_res_id", 32'(bus.res_id), 0);
    chk("midrst_res_c_r", 32'(bus.res_c_r), 0);
    chk("midrst_res_c_i", 32'(bus.res_c_i), 0);
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    expq.delete();
    m_rr  = 0;
    m_out = 0;
    chk("postrst_cred", 32'(dut.cred), DEPTH);

    // Fairness from a fresh reset: grants rotate 0,1,2,3,0...
    for (int k = 0; k < 12; k++) begin
      run_cycle('1, 1'b1, 1'b1);
      chk("rr_grant", 32'(last_ready), 32'(NREQ'(1) << (k % NREQ)));
    end
    for (int k = 0; k < 12; k++) run_cycle('0, 1'b1, 1'b1);
    chk("rr_drained", expq.size(), 0);

    // Random valids and random backpressure against the scoreboard.
    thr = 70;
    for (int k = 0; k < 10000; k++) begin
      if (k % 500 == 0) thr = $urandom_range(10, 95);
      run_cycle(NREQ'($urandom_range(0, 15)), 1'($urandom_range(0, 99) < thr), 1'b1);
    end
    for (int k = 0; k < 30; k++) run_cycle('0, 1'b1, 1'b1);
    chk("final_drained", expq.size(), 0);
    chk("final_cred", 32'(dut.cred), DEPTH);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
